carfield_mailbox_responder: RTL and testbench



---
 rtl/carfield_mailbox_responder.sv | 138 +++++++++++++
 tb/tb_carfield_mailbox_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/carfield_mailbox_responder.sv
// Inter-domain mailbox window on RegBus: per-mailbox data words, doorbell
// status/enable, and a doorbell sequence counter, with one level IRQ each.
module carfield_mailbox_responder #(
  parameter int unsigned NumMbox   = 4,
  parameter int unsigned AddrWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  output logic                 reg_ready_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_error_o,
  output logic [NumMbox-1:0]   irq_o
);

  localparam int unsigned IdxW = AddrWidth - 5;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [31:0]        data0_q [NumMbox];
  logic [31:0]        data0_d [NumMbox];
  logic [31:0]        data1_q [NumMbox];
  logic [31:0]        data1_d [NumMbox];
  logic [7:0]         seq_q   [NumMbox];
  logic [7:0]         seq_d   [NumMbox];
  logic [NumMbox-1:0] status_q, status_d;
  logic [NumMbox-1:0] en_q, en_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [IdxW-1:0] idx;
  logic [2:0]      reg_sel;
  logic            decode_err;
  logic            db_hit;
  logic [31:0]     wmask;
  logic [31:0]     rd_word;

  assign idx     = reg_addr_i[AddrWidth-1:5];
  assign reg_sel = reg_addr_i[4:2];
  assign db_hit  = reg_wstrb_i[0] & reg_wdata_i[0];
  assign wmask   = {{8{reg_wstrb_i[3]}}, {8{reg_wstrb_i[2]}},
                    {8{reg_wstrb_i[1]}}, {8{reg_wstrb_i[0]}}};

  // Index compared at 32 bits so NumMbox == 2**IdxW cannot alias to zero.
  assign decode_err = (32'(idx) >= NumMbox)
                    | (reg_addr_i[1:0] != 2'b00)
                    | (reg_sel == 3'd7)
                    | (reg_write_i & ((reg_sel == 3'd4) | (reg_sel == 3'd6)));

  always_comb begin
    state_d  = state_q;
    rdata_d  = '0;
    err_d    = 1'b0;
    rd_word  = '0;
    data0_d  = data0_q;
    data1_d  = data1_q;
    seq_d    = seq_q;
    status_d = status_q;
    en_d     = en_q;
    unique case (state_q)
      IDLE: begin
        if (reg_valid_i) begin
          state_d = RESP;
          err_d   = decode_err;
          for (int unsigned i = 0; i < NumMbox; i++) begin
            if (!decode_err && (32'(idx) == i)) begin
              if (reg_write_i) begin
                case (reg_sel)
                  3'd0: data0_d[i] = (data0_q[i] & ~wmask) | (reg_wdata_i & wmask);
                  3'd1: data1_d[i] = (data1_q[i] & ~wmask) | (reg_wdata_i & wmask);
                  3'd2: if (db_hit) begin
                    status_d[i] = 1'b1;
                    seq_d[i]    = seq_q[i] + 8'd1;
                  end
                  3'd3: if (db_hit) status_d[i] = 1'b0;
                  3'd5: if (reg_wstrb_i[0]) en_d[i] = reg_wdata_i[0];
                  default: ;
                endcase
              end else begin
                case (reg_sel)
                  3'd0:    rd_word = data0_q[i];
                  3'd1:    rd_word = data1_q[i];
                  3'd4:    rd_word = {31'd0, status_q[i]};
                  3'd5:    rd_word = {31'd0, en_q[i]};
                  3'd6:    rd_word = {24'd0, seq_q[i]};
                  default: rd_word = '0;
                endcase
              end
            end
          end
          rdata_d = rd_word;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      status_q <= '0;
      en_q     <= '0;
      for (int unsigned i = 0; i < NumMbox; i++) begin
        data0_q[i] <= '0;
        data1_q[i] <= '0;
        seq_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      status_q <= status_d;
      en_q     <= en_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      seq_q    <= seq_d;
    end
  end

  // Response flops hold zero outside RESP, so no output gating is needed.
  assign reg_ready_o = (state_q == RESP);
  assign reg_rdata_o = rdata_q;
  assign reg_error_o = err_q;
  assign irq_o       = status_q & en_q;

endmodule

// File: tb/tb_carfield_mailbox_responder.sv
// Directed bench for the mailbox responder: vector table plus hand-written
// sequences for SEQ wrap, held-valid back-to-back and reset during RESP.
module tb_carfield_mailbox_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, write;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready, error;
  logic [31:0] rdata;
  logic [3:0]  irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  carfield_mailbox_responder #(.NumMbox(4), .AddrWidth(12)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .reg_valid_i (valid),
    .reg_write_i (write),
    .reg_addr_i  (addr),
    .reg_wdata_i (wdata),
    .reg_wstrb_i (wstrb),
    .reg_ready_o (ready),
    .reg_rdata_o (rdata),
    .reg_error_o (error),
    .irq_o       (irq)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request: accept edge, ready exactly one cycle later, then low again.
  task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd,
                      output logic er, output logic [3:0] iq);
    valid = 1'b1; write = w; addr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    check("ready_after_accept", 32'(ready), 32'd1);
    rd = rdata; er = error; iq = irq;
    valid = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(ready), 32'd0);
  endtask

  function automatic vec_t mk(input logic w, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] r,
                              input logic e, input logic [3:0] i);
    vec_t v;
    v.wr = w; v.addr = a; v.wdata = d; v.wstrb = s;
    v.exp_rdata = r; v.exp_err = e; v.exp_irq = i;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [3:0]  iq;
    logic [3:0]  rpat;

    rst_n = 1'b0; valid = 1'b0; write = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_irq",   32'(irq), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Data and strobes
    vecs.push_back(mk(1, 12'h000, 32'hDEADBEEF, 4'hF, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 12'h000, 32'h11223344, 4'h5, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 32'hDE22BE44, 0, 4'b0000));
    vecs.push_back(mk(1, 12'h004, 32'hA5A5A5A5, 4'h0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 12'h004, 0, 0, 32'h0, 0, 4'b0000));
    // Doorbell on mbox1
    vecs.push_back(mk(1, 12'h034, 1, 4'h1, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 12'h028, 1, 4'h1, 0, 0, 4'b0010));
    vecs.push_back(mk(0, 12'h030, 0, 0, 32'h1, 0, 4'b0010));
    vecs.push_back(mk(1, 12'h028, 1, 4'hF, 0, 0, 4'b0010));
    vecs.push_back(mk(0, 12'h038, 0, 0, 32'h2, 0, 4'b0010));
    vecs.push_back(mk(1, 12'h02C, 1, 4'h1, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 12'h038, 0, 0, 32'h2, 0, 4'b0000));
    vecs.push_back(mk(1, 12'h04C, 1, 4'h1, 0, 0, 4'b0000));
    // Masking on mbox3
    vecs.push_back(mk(1, 12'h068, 1, 4'h1, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 12'h070, 0, 0, 32'h1, 0, 4'b0000));
    vecs.push_back(mk(1, 12'h074, 1, 4'h1, 0, 0, 4'b1000));
    // No-op doorbell writes: wdata[0]=0, zero strobe, bit0 strobe off
    vecs.push_back(mk(1, 12'h068, 0, 4'hF, 0, 0, 4'b1000));
    vecs.push_back(mk(1, 12'h06C, 1, 4'h0, 0, 0, 4'b1000));
    vecs.push_back(mk(1, 12'h06C, 1, 4'hE, 0, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h078, 0, 0, 32'h1, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h008, 0, 0, 32'h0, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h00C, 0, 0, 32'h0, 0, 4'b1000));
    // Errors
    vecs.push_back(mk(0, 12'h080, 0, 0, 32'h0, 1, 4'b1000));
    vecs.push_back(mk(0, 12'h01C, 0, 0, 32'h0, 1, 4'b1000));
    vecs.push_back(mk(1, 12'h002, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 4'b1000));
    vecs.push_back(mk(0, 12'h003, 0, 0, 32'h0, 1, 4'b1000));
    vecs.push_back(mk(1, 12'h010, 1, 4'hF, 32'h0, 1, 4'b1000));
    vecs.push_back(mk(1, 12'h018, 5, 4'hF, 32'h0, 1, 4'b1000));
    vecs.push_back(mk(1, 12'h070, 0, 4'hF, 32'h0, 1, 4'b1000));
    // State unchanged after the errors
    vecs.push_back(mk(0, 12'h000, 0, 0, 32'hDE22BE44, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h004, 0, 0, 32'h0, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h010, 0, 0, 32'h0, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h014, 0, 0, 32'h0, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h018, 0, 0, 32'h0, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h020, 0, 0, 32'h0, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h030, 0, 0, 32'h0, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h034, 0, 0, 32'h1, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h038, 0, 0, 32'h2, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h070, 0, 0, 32'h1, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h074, 0, 0, 32'h1, 0, 4'b1000));
    vecs.push_back(mk(0, 12'h078, 0, 0, 32'h1, 0, 4'b1000));

    foreach (vecs[k]) begin
      xfer(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb, rd, er, iq);
      check($sformatf("vec%0d_err@%03h", k, vecs[k].addr), 32'(er), 32'(vecs[k].exp_err));
      check($sformatf("vec%0d_irq@%03h", k, vecs[k].addr), 32'(iq), 32'(vecs[k].exp_irq));
      if (!vecs[k].wr || vecs[k].exp_err)
        check($sformatf("vec%0d_rdata@%03h", k, vecs[k].addr), rd, vecs[k].exp_rdata);
    end

    // SEQ wrap on mbox0: 256 sets -> 0x00, one more -> 0x01
    for (int n = 0; n < 256; n++) xfer(1'b1, 12'h008, 32'h1, 4'h1, rd, er, iq);
    xfer(1'b0, 12'h018, '0, '0, rd, er, iq);
    check("seq_wrap_256", rd, 32'h00);
    xfer(1'b0, 12'h010, '0, '0, rd, er, iq);
    check("status_after_wrap", rd, 32'h1);
    xfer(1'b1, 12'h008, 32'h1, 4'h1, rd, er, iq);
    xfer(1'b0, 12'h018, '0, '0, rd, er, iq);
    check("seq_wrap_257", rd, 32'h01);

    // Valid held through RESP: accepted again one cycle later (ready 1,0,1,0)
    valid = 1'b1; write = 1'b1; addr = 12'h048; wdata = 32'h1; wstrb = 4'h1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      rpat[c] = ready;
    end
    valid = 1'b0;
    @(posedge clk); #1;
    check("held_valid_ready_pattern", 32'(rpat), 32'b0101);
    xfer(1'b0, 12'h058, '0, '0, rd, er, iq);
    check("held_valid_seq", rd, 32'h2);

    // Async reset in the middle of a RESP cycle
    valid = 1'b1; write = 1'b0; addr = 12'h000; wdata = '0; wstrb = '0;
    @(posedge clk); #1;
    check("pre_reset_ready", 32'(ready), 32'd1);
    check("pre_reset_rdata", rdata, 32'hDE22BE44);
    valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_irq",   32'(irq), 32'd0);
    check("rst_mid_error", 32'(error), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("no_retry_ready", 32'(ready), 32'd0);
    xfer(1'b0, 12'h018, '0, '0, rd, er, iq);
    check("post_reset_seq", rd, 32'h0);
    xfer(1'b0, 12'h000, '0, '0, rd, er, iq);
    check("post_reset_data0", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
